pseudo_coloring: RTL

Pseudo-color expander: converts a stream of single-channel gray pixels into packed RGB pixels, either by channel replication or by a 4-segment "jet" false-color map. It is the inverse-direction counterpart of the graying stage in the Image/Point pipeline. It uses the same `in_enable`/`out_ready` streaming convention and the same `{R,G,B}` packing, with R in the MSBs. It is a 2-stage registered pipeline with a saturating fill counter.

---
 rtl/pseudo_coloring_pkg.sv | 12 +
 rtl/jet_segment_map.sv | 29 ++
 rtl/pseudo_coloring.sv | 55 +++++
 3 files changed

// File: rtl/pseudo_coloring_pkg.sv
// Shared constants for the pseudo-color expander: mode codes, jet segments, fill latency.
package pseudo_coloring_pkg;
    localparam int MODE_REPLICATE = 0;
    localparam int MODE_JET       = 1;

    localparam logic [1:0] SEG_0 = 2'd0;
    localparam logic [1:0] SEG_1 = 2'd1;
    localparam logic [1:0] SEG_2 = 2'd2;
    localparam logic [1:0] SEG_3 = 2'd3;

    localparam logic [1:0] FILL_LAT = 2'd2;
endpackage

// File: rtl/jet_segment_map.sv
// Combinational 4-segment jet false-color map: segment + ramp position -> packed {R,G,B}.
module jet_segment_map
    import pseudo_coloring_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]     i_seg,
    input  logic [W-3:0]   i_t,
    output logic [3*W-1:0] o_rgb
);
    logic [W-1:0] w_up;
    logic [W-1:0] w_dn;
    logic [W-1:0] w_full;

    assign w_up   = {i_t, 2'b00};
    assign w_dn   = ~w_up;
    assign w_full = '1;

    always_comb begin
        o_rgb = '0;
        case (i_seg)
            SEG_0:   o_rgb = {{W{1'b0}}, w_up,   w_full};
            SEG_1:   o_rgb = {{W{1'b0}}, w_full, w_dn};
            SEG_2:   o_rgb = {w_up,      w_full, {W{1'b0}}};
            SEG_3:   o_rgb = {w_full,    w_dn,   {W{1'b0}}};
            default: o_rgb = '0;
        endcase
    end
endmodule

// File: rtl/pseudo_coloring.sv
// Gray-to-RGB expander: 2-stage pipeline (gray register, packed RGB register) gated by a
// saturating fill counter so out_ready only rises once a full pixel has propagated.
module pseudo_coloring
    import pseudo_coloring_pkg::*;
#(
    parameter int work_mode   = MODE_JET,
    parameter int color_width = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_enable,
    input  logic [color_width-1:0]     in_data,
    output logic                       out_ready,
    output logic [3*color_width-1:0]   out_data
);
    localparam int W = color_width;

    logic [1:0]     r_cnt;
    logic [W-1:0]   r_gray;
    logic [3*W-1:0] r_rgb;
    logic [3*W-1:0] w_rgb;

    generate
        if (work_mode == MODE_REPLICATE) begin : g_rep
            assign w_rgb = {3{r_gray}};
        end else begin : g_jet
            jet_segment_map #(.W(W)) u_map (
                .i_seg (r_gray[W-1:W-2]),
                .i_t   (r_gray[W-3:0]),
                .o_rgb (w_rgb)
            );
        end
    endgenerate

    // A low in_enable sample flushes everything, so no pixel from a previous run survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_gray <= '0;
            r_rgb  <= '0;
        end else if (!in_enable) begin
            r_cnt  <= '0;
            r_gray <= '0;
            r_rgb  <= '0;
        end else begin
            r_gray <= in_data;
            r_rgb  <= w_rgb;
            if (r_cnt != FILL_LAT)
                r_cnt <= r_cnt + 2'd1;
        end
    end

    assign out_ready = (r_cnt == FILL_LAT);
    assign out_data  = out_ready ? r_rgb : '0;
endmodule
